// File: rtl/pipe_bpred_pkg.sv
// pipe_bpred_pkg
//   Shared definitions for the dynamic branch predictor:
//   - bpred_state_e : table-initialisation FSM states (ST_INIT sweeps, ST_RUN predicts)
//   - MODE_BIMODAL / MODE_GSHARE : values of the MODE parameter
//   - cnt_weak_taken / cnt_weak_not_taken : counter start values for a given counter width
package pipe_bpred_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Weak-taken: MSB set, everything else clear (10..0).
  function automatic int unsigned cnt_weak_taken(input int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weak-not-taken: MSB clear, next bit set (01..0).
  function automatic int unsigned cnt_weak_not_taken(input int cnt_w);
    return 32'd1 << (cnt_w - 2);
  endfunction

endpackage

// File: rtl/bpred_sat_counter.sv
// bpred_sat_counter
//   Combinational next-value for an up/down saturating counter.
//   Ports:
//     cnt      in  CNT_W  current counter value
//     inc      in  1      1 = count up, 0 = count down
//     cnt_next out CNT_W  saturated next value (clamped to 0 and 2^CNT_W-1)
module bpred_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
    end else begin
      if (cnt != '0) cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_branch_predictor.sv
// pipe_branch_predictor
//   Dynamic branch predictor for the 5-stage pipeline. A direct-indexed BTB with a
//   tag, target and saturating counter per entry. IF looks it up combinationally; ID
//   reports each resolved branch, which trains the table and raises mispredict with
//   the recovery PC.
//
//   Optional feature macro: BPRED_STATS_EN builds the resolved-branch and mispredict
//   counters; without it stat_branches / stat_mispredicts are tied to 0.
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset (restarts table sweep)
//     if_pc                  PC in IF; pred_hit / pred_taken / pred_target same cycle
//     stall                  blocks table/history/stat updates while high
//     upd_valid, upd_pc,     resolved branch from ID: outcome, actual target and the
//     upd_taken, upd_target, prediction that travelled with it
//     upd_pred_taken, upd_pred_target
//     mispredict, recover_pc flush request and redirect PC
//     ready                  table fully initialised
//     stat_branches, stat_mispredicts  saturating event counters
module pipe_branch_predictor
  import pipe_bpred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = MODE_BIMODAL,
  parameter int HIST_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        stall,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] recover_pc,
  output logic        ready,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN     = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NOT_TAKEN = CNT_W'(cnt_weak_not_taken(CNT_W));

  // Table storage
  logic             entry_valid  [ENTRIES];
  logic [TAG_W-1:0] entry_tag    [ENTRIES];
  logic [31:0]      entry_target [ENTRIES];
  logic [CNT_W-1:0] entry_cnt    [ENTRIES];

  bpred_state_e     state_reg;
  logic [IDX_W-1:0] init_idx_reg;
  logic             ready_reg;

  logic             accept;
  logic [IDX_W-1:0] hist_idx;

  assign accept = (state_reg == ST_RUN) && upd_valid && !stall;
  assign ready  = ready_reg;

  // Global history: only exists in gshare mode. It is non-speculative, so it
  // shifts only when a resolved branch is accepted.
  generate
    if (MODE == MODE_GSHARE) begin : g_gshare
      logic [HIST_W-1:0] ghr_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr_reg <= '0;
        end else if (accept) begin
          ghr_reg <= (ghr_reg << 1) | HIST_W'(upd_taken);
        end
      end
      assign hist_idx = IDX_W'(ghr_reg);
    end else begin : g_bimodal
      assign hist_idx = '0;
    end
  endgenerate

  // Lookup (IF). Gated by ready so stale contents are never used mid-sweep.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx      = if_pc[IDX_W+1:2] ^ hist_idx;
  assign lk_tag      = if_pc[IDX_W+2 +: TAG_W];
  assign pred_hit    = ready_reg && entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && entry_cnt[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? entry_target[lk_idx] : (if_pc + 32'd4);

  // Update (ID)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CNT_W-1:0] up_cnt_next;

  assign up_idx = upd_pc[IDX_W+1:2] ^ hist_idx;
  assign up_tag = upd_pc[IDX_W+2 +: TAG_W];
  assign up_hit = entry_valid[up_idx] && (entry_tag[up_idx] == up_tag);

  bpred_sat_counter #(
    .CNT_W (CNT_W)
  ) u_upd_cnt (
    .cnt      (entry_cnt[up_idx]),
    .inc      (upd_taken),
    .cnt_next (up_cnt_next)
  );

  assign mispredict = accept &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
  assign recover_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

  // FSM: reset restarts the sweep at index 0; the last cleared index enters RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= '0;
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
          if (init_idx_reg == IDX_W'(ENTRIES - 1)) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end
        end
        ST_RUN: ;
        default: begin
          state_reg    <= ST_INIT;
          init_idx_reg <= '0;
          ready_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: either the init sweep or an accepted update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == ST_INIT) begin
        entry_valid[init_idx_reg]  <= 1'b0;
        entry_tag[init_idx_reg]    <= '0;
        entry_target[init_idx_reg] <= '0;
        entry_cnt[init_idx_reg]    <= CNT_WEAK_NOT_TAKEN;
      end else if (accept) begin
        if (up_hit) begin
          entry_cnt[up_idx] <= up_cnt_next;
          if (upd_taken) entry_target[up_idx] <= upd_target;
        end else if (upd_taken) begin
          entry_valid[up_idx]  <= 1'b1;
          entry_tag[up_idx]    <= up_tag;
          entry_target[up_idx] <= upd_target;
          entry_cnt[up_idx]    <= CNT_WEAK_TAKEN;
        end
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] branches_reg;
  logic [31:0] mispredicts_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else begin
      if (accept && (branches_reg != 32'hFFFF_FFFF))
        branches_reg <= branches_reg + 32'd1;
      if (mispredict && (mispredicts_reg != 32'hFFFF_FFFF))
        mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = branches_reg;
  assign stat_mispredicts = mispredicts_reg;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
